// File: rtl/sum_accumulator.sv
// Block accumulator for registered adder results: sums a programmed number of
// {carry, sum} operands into a wide total and offers it on a valid/ready port.
module sum_accumulator #(
   parameter int N     = 8,
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   input  logic             in_valid,
   input  logic [N-1:0]     in_sum,
   input  logic             in_carry,
   output logic             busy,
   output logic [CNT_W-1:0] cnt,
   output logic [ACC_W-1:0] acc,
   output logic             ovf,
   output logic             out_valid,
   input  logic             out_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state_r;
   state_t           next_state_s;

   logic [CNT_W-1:0] len_r;
   logic [CNT_W-1:0] cnt_r;
   logic [ACC_W-1:0] acc_r;
   logic             ovf_r;
   logic             out_valid_r;

   logic [CNT_W-1:0] len_nxt_s;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic [ACC_W-1:0] acc_nxt_s;
   logic             ovf_nxt_s;

   logic [ACC_W-1:0] operand_s;
   logic [ACC_W:0]   sum_s;
   logic [CNT_W-1:0] cnt_inc_s;
   logic             start_ok_s;
   logic             last_s;

   // The extra top bit of sum_s is the carry out of the accumulator.
   assign operand_s  = ACC_W'({in_carry, in_sum});
   assign sum_s      = {1'b0, acc_r} + {1'b0, operand_s};
   assign cnt_inc_s  = cnt_r + CNT_W'(1);
   assign start_ok_s = start && (len != {CNT_W{1'b0}});
   assign last_s     = in_valid && (cnt_inc_s == len_r);

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               next_state_s = ACCUM;
            end else begin
               next_state_s = IDLE;
            end
         end
         ACCUM: begin
            if (last_s) begin
               next_state_s = DONE;
            end else begin
               next_state_s = ACCUM;
            end
         end
         DONE: begin
            if (out_ready) begin
               next_state_s = IDLE;
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Datapath next values; everything holds unless a block starts or a sample lands
   always_comb begin
      len_nxt_s = len_r;
      cnt_nxt_s = cnt_r;
      acc_nxt_s = acc_r;
      ovf_nxt_s = ovf_r;
      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               len_nxt_s = len;
               cnt_nxt_s = {CNT_W{1'b0}};
               acc_nxt_s = {ACC_W{1'b0}};
               ovf_nxt_s = 1'b0;
            end else begin
               len_nxt_s = len_r;
            end
         end
         ACCUM: begin
            if (in_valid) begin
               cnt_nxt_s = cnt_inc_s;
               acc_nxt_s = sum_s[ACC_W-1:0];
               ovf_nxt_s = ovf_r | sum_s[ACC_W];
            end else begin
               cnt_nxt_s = cnt_r;
            end
         end
         DONE: begin
            cnt_nxt_s = cnt_r;
         end
         default: begin
            cnt_nxt_s = cnt_r;
         end
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len_r       <= {CNT_W{1'b0}};
         cnt_r       <= {CNT_W{1'b0}};
         acc_r       <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         out_valid_r <= 1'b0;
      end else begin
         len_r       <= len_nxt_s;
         cnt_r       <= cnt_nxt_s;
         acc_r       <= acc_nxt_s;
         ovf_r       <= ovf_nxt_s;
         out_valid_r <= (next_state_s == DONE);
      end
   end

   assign busy      = (state_r != IDLE);
   assign cnt       = cnt_r;
   assign acc       = acc_r;
   assign ovf       = ovf_r;
   assign out_valid = out_valid_r;

   sum_accumulator_chk #(
      .ACC_W (ACC_W),
      .CNT_W (CNT_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .busy      (busy),
      .cnt       (cnt_r),
      .len_lat   (len_r),
      .acc       (acc_r),
      .out_valid (out_valid_r),
      .out_ready (out_ready)
   );

endmodule

// Protocol checker for the accumulator's result port.
module sum_accumulator_chk #(
   parameter int ACC_W = 16,
   parameter int CNT_W = 8
) (
   input logic             clk,
   input logic             rst,
   input logic             busy,
   input logic [CNT_W-1:0] cnt,
   input logic [CNT_W-1:0] len_lat,
   input logic [ACC_W-1:0] acc,
   input logic             out_valid,
   input logic             out_ready
);

   a_valid_busy : assert property (@(posedge clk) disable iff (!rst)
      out_valid |-> busy);

   a_cnt_bound : assert property (@(posedge clk) disable iff (!rst)
      busy |-> (cnt <= len_lat));

   // A stalled result must not move until the sink takes it.
   a_hold : assert property (@(posedge clk) disable iff (!rst)
      (out_valid && !out_ready) |=> (out_valid && $stable(acc) && $stable(cnt)));

   a_drop : assert property (@(posedge clk) disable iff (!rst)
      (out_valid && out_ready) |=> !out_valid);

endmodule

// File: tb/tb_sum_accumulator.sv
// Bench for sum_accumulator: table-driven blocks checked through a result
// scoreboard, plus hand sequences for backpressure, ignored starts and reset.
module tb_sum_accumulator;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  len;
   logic        in_valid;
   logic [7:0]  in_sum;
   logic        in_carry;
   logic        busy;
   logic [7:0]  cnt;
   logic [15:0] acc;
   logic        ovf;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0]      len;
      logic [3:0][8:0] ops;
      int              gap;
      logic [15:0]     acc;
      logic [7:0]      cnt;
      logic            ovf;
   } vec_t;

   typedef struct {
      logic [15:0] acc;
      logic [7:0]  cnt;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   vec_t vecs[7];

   sum_accumulator #(.N(8), .ACC_W(16), .CNT_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .len       (len),
      .in_valid  (in_valid),
      .in_sum    (in_sum),
      .in_carry  (in_carry),
      .busy      (busy),
      .cnt       (cnt),
      .acc       (acc),
      .ovf       (ovf),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Wait for out_valid, returning how many extra cycles it took.
   task automatic wait_valid(output int k);
      k = 0;
      while (!out_valid && k < 20) begin
         tick();
         k++;
      end
   endtask

   task automatic run_block(input vec_t v);
      exp_t e;
      int   k;
      start = 1'b1;
      len   = v.len;
      tick();
      start = 1'b0;
      len   = 8'($urandom);
      check("busy_accum", busy, 1);
      sb.push_back('{acc: v.acc, cnt: v.cnt, ovf: v.ovf});
      for (int i = 0; i < int'(v.len); i++) begin
         in_valid = 1'b1;
         {in_carry, in_sum} = v.ops[i % 4];
         tick();
         in_valid = 1'b0;
         if (i != int'(v.len) - 1) begin
            for (int g = 0; g < v.gap; g++) begin
               tick();
               check("gap_cnt", cnt, i + 1);
               check("gap_no_valid", out_valid, 0);
            end
         end
      end
      wait_valid(k);
      check("latency", k, 0);
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check("acc", acc, e.acc);
         check("cnt", cnt, e.cnt);
         check("ovf", ovf, e.ovf);
      end else begin
         check("sb_empty", 1, 0);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("valid_drop", out_valid, 0);
      check("busy_idle", busy, 0);
   endtask

   initial begin
      #400000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int   k;
      exp_t e;
      logic [15:0] hold_acc;
      logic [7:0]  hold_cnt;

      vecs[0] = '{len: 8'd3,   ops: {9'd0,   9'd5,   9'd200, 9'd256}, gap: 0, acc: 16'd461,   cnt: 8'd3,   ovf: 1'b0};
      vecs[1] = '{len: 8'd4,   ops: {9'd256, 9'd256, 9'd256, 9'd256}, gap: 2, acc: 16'd1024,  cnt: 8'd4,   ovf: 1'b0};
      vecs[2] = '{len: 8'd255, ops: {9'd511, 9'd511, 9'd511, 9'd511}, gap: 0, acc: 16'd64769, cnt: 8'd255, ovf: 1'b1};
      vecs[3] = '{len: 8'd128, ops: {9'd511, 9'd511, 9'd511, 9'd511}, gap: 0, acc: 16'd65408, cnt: 8'd128, ovf: 1'b0};
      vecs[4] = '{len: 8'd130, ops: {9'd511, 9'd511, 9'd511, 9'd511}, gap: 1, acc: 16'd894,   cnt: 8'd130, ovf: 1'b1};
      vecs[5] = '{len: 8'd2,   ops: {9'd0,   9'd0,   9'd510, 9'd510}, gap: 3, acc: 16'd1020,  cnt: 8'd2,   ovf: 1'b0};
      vecs[6] = '{len: 8'd255, ops: {9'd0,   9'd0,   9'd0,   9'd0},   gap: 0, acc: 16'd0,     cnt: 8'd255, ovf: 1'b0};

      rst = 1'b0; start = 1'b0; len = 8'd0; in_valid = 1'b0;
      in_sum = 8'd0; in_carry = 1'b0; out_ready = 1'b0;
      #12;
      check("rst_busy", busy, 0);
      check("rst_cnt", cnt, 0);
      check("rst_acc", acc, 0);
      check("rst_ovf", ovf, 0);
      check("rst_valid", out_valid, 0);
      rst = 1'b1;
      tick();

      // In IDLE, samples are ignored.
      in_valid = 1'b1; {in_carry, in_sum} = 9'd100;
      tick(); tick();
      in_valid = 1'b0;
      check("idle_ignore_acc", acc, 0);
      check("idle_ignore_busy", busy, 0);

      for (int i = 0; i < 7; i++) begin
         run_block(vecs[i]);
      end
      check("hold_prev_acc", acc, 0);

      // Backpressure: stall in DONE while pushing samples and starts.
      start = 1'b1; len = 8'd2; tick(); start = 1'b0;
      sb.push_back('{acc: 16'd30, cnt: 8'd2, ovf: 1'b0});
      in_valid = 1'b1; {in_carry, in_sum} = 9'd10; tick();
      {in_carry, in_sum} = 9'd20; tick();
      check("bp_valid", out_valid, 1);
      hold_acc = 16'd30; hold_cnt = 8'd2;
      start = 1'b1; len = 8'd9; {in_carry, in_sum} = 9'd77;
      for (int c = 0; c < 5; c++) begin
         tick();
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_acc", acc, hold_acc);
         check("bp_hold_cnt", cnt, hold_cnt);
      end
      e = sb.pop_front();
      check("bp_acc", acc, e.acc);
      out_ready = 1'b1;
      tick();
      start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("bp_drop", out_valid, 0);
      check("bp_no_restart", busy, 0);
      tick();
      check("bp_still_idle", busy, 0);

      // Zero length start is ignored; a second start during ACCUM too.
      start = 1'b1; len = 8'd0; tick(); start = 1'b0;
      check("zero_len_busy", busy, 0);
      start = 1'b1; len = 8'd2; tick();
      len = 8'd7; out_ready = 1'b1;
      in_valid = 1'b1; {in_carry, in_sum} = 9'd3; tick();
      start = 1'b0;
      {in_carry, in_sum} = 9'd4; tick();
      in_valid = 1'b0;
      check("restart_valid", out_valid, 1);
      check("restart_cnt", cnt, 2);
      check("restart_acc", acc, 7);
      tick();
      out_ready = 1'b0;
      check("early_ready_drop", out_valid, 0);
      check("early_ready_idle", busy, 0);

      // Reset mid-block aborts immediately.
      start = 1'b1; len = 8'd5; tick(); start = 1'b0;
      in_valid = 1'b1; {in_carry, in_sum} = 9'd50;
      tick(); tick(); tick();
      in_valid = 1'b0;
      check("mid_cnt", cnt, 3);
      #2;
      rst = 1'b0;
      #1;
      check("abort_acc", acc, 0);
      check("abort_cnt", cnt, 0);
      check("abort_ovf", ovf, 0);
      check("abort_busy", busy, 0);
      #1;
      rst = 1'b1;
      tick();
      run_block('{len: 8'd1, ops: {9'd7, 9'd7, 9'd7, 9'd7}, gap: 0, acc: 16'd7, cnt: 8'd1, ovf: 1'b0});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
